// File: rtl/chnlnk_frame_packer.sv
// -----------------------------------------------------------------------------
// chnlnk_frame_packer
//
// Packs the frame sequencer's per-sample word stream into a registered 16-bit
// 8b/10b-ready word stream for the optical transmitter. Each frame carries data
// words 0..95, then a status word (96), a running checksum (97) and a trailer
// (98). Gaps and inter-frame time are filled with idle commas. Sequence
// continuity is checked; frames and events are counted.
//
// Ports:
//   clk       in   1   system clock, rising edge
//   rst_n     in   1   asynchronous active-low reset
//   din       in  16   data word, qualified by valid
//   valid     in   1   a word is presented this cycle
//   seq       in   7   word index within the frame (0..98)
//   clr_crc   in   1   start-of-frame pulse: clears checksum and index
//   last_wrd  in   1   end-of-event pulse
//   clr_err   in   1   synchronous clear of seq_err
//   tx_data   out 16   output word (registered)
//   tx_k      out  2   K-character flags per byte, bit0 = low byte
//   frm_done  out  1   pulse in the cycle the trailer is output
//   seq_err   out  1   sticky sequence-error flag
//   frm_cnt   out  7   frames sent in the current event
//   evt_cnt   out 12   events completed (wraps)
// -----------------------------------------------------------------------------
module chnlnk_frame_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] din,
    input  logic        valid,
    input  logic [6:0]  seq,
    input  logic        clr_crc,
    input  logic        last_wrd,
    input  logic        clr_err,
    output logic [15:0] tx_data,
    output logic [1:0]  tx_k,
    output logic        frm_done,
    output logic        seq_err,
    output logic [6:0]  frm_cnt,
    output logic [11:0] evt_cnt
);

    localparam logic [15:0] IDLE_WORD = 16'h50BC;
    localparam logic [15:0] TRL_WORD  = 16'hFCF7;
    localparam logic [15:0] EOE_WORD  = 16'hF7F7;
    localparam logic [1:0]  K_IDLE    = 2'b01;
    localparam logic [1:0]  K_NONE    = 2'b00;
    localparam logic [1:0]  K_BOTH    = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } state_t;

    state_t      state_q,    state_d;
    logic [6:0]  exp_q,      exp_d;
    logic [15:0] csum_q,     csum_d;
    logic [15:0] tx_data_q,  tx_data_d;
    logic [1:0]  tx_k_q,     tx_k_d;
    logic        frm_done_q, frm_done_d;
    logic        seq_err_q,  seq_err_d;
    logic [6:0]  frm_cnt_q,  frm_cnt_d;
    logic [11:0] evt_cnt_q,  evt_cnt_d;
    logic        err_set;

    // Rotate-left-by-one then XOR in the new word.
    function automatic logic [15:0] csum_step(input logic [15:0] c, input logic [15:0] w);
        return {c[14:0], c[15]} ^ w;
    endfunction

    function automatic logic [15:0] status_word(input logic err, input logic [6:0] cnt);
        return {4'hD, err, 4'b0000, cnt};
    endfunction

    // Next-state and next-output logic. Priority: clr_crc, then last_wrd,
    // then valid; a lower-priority input coincident with a higher one is dropped.
    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        csum_d     = csum_q;
        tx_data_d  = IDLE_WORD;
        tx_k_d     = K_IDLE;
        frm_done_d = 1'b0;
        frm_cnt_d  = frm_cnt_q;
        evt_cnt_d  = evt_cnt_q;
        err_set    = 1'b0;

        if (clr_crc) begin
            csum_d  = 16'h0000;
            exp_d   = 7'd0;
            state_d = ST_IDLE;
            // Restarting a frame that already accepted words is an abort.
            if (state_q == ST_FRAME && exp_q != 7'd0) begin
                err_set = 1'b1;
            end
        end else if (last_wrd) begin
            tx_data_d = EOE_WORD;
            tx_k_d    = K_BOTH;
            evt_cnt_d = evt_cnt_q + 12'd1;
            frm_cnt_d = 7'd0;
            if (state_q == ST_FRAME) begin
                err_set = 1'b1;
                state_d = ST_IDLE;
                exp_d   = 7'd0;
            end
        end else if (valid) begin
            if (state_q == ST_IDLE) begin
                if (seq == 7'd0) begin
                    tx_data_d = din;
                    tx_k_d    = K_NONE;
                    csum_d    = csum_step(csum_q, din);
                    exp_d     = 7'd1;
                    state_d   = ST_FRAME;
                end else begin
                    err_set = 1'b1;
                end
            end else if (seq != exp_q) begin
                // Discontinuity: discard the rest of the frame until the next seq 0.
                err_set = 1'b1;
                state_d = ST_IDLE;
                exp_d   = 7'd0;
            end else begin
                exp_d = exp_q + 7'd1;
                case (exp_q)
                    7'd96: begin
                        tx_data_d = status_word(seq_err_q, frm_cnt_q);
                        tx_k_d    = K_NONE;
                        csum_d    = csum_step(csum_q, status_word(seq_err_q, frm_cnt_q));
                    end
                    7'd97: begin
                        tx_data_d = csum_q;
                        tx_k_d    = K_NONE;
                    end
                    7'd98: begin
                        tx_data_d  = TRL_WORD;
                        tx_k_d     = K_BOTH;
                        frm_done_d = 1'b1;
                        frm_cnt_d  = frm_cnt_q + 7'd1;
                        state_d    = ST_IDLE;
                        exp_d      = 7'd0;
                    end
                    default: begin
                        tx_data_d = din;
                        tx_k_d    = K_NONE;
                        csum_d    = csum_step(csum_q, din);
                    end
                endcase
            end
        end

        // A new error in the same cycle wins over the clear.
        seq_err_d = err_set | (seq_err_q & ~clr_err);
    end

    // Output and state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            exp_q      <= 7'd0;
            csum_q     <= 16'h0000;
            tx_data_q  <= IDLE_WORD;
            tx_k_q     <= K_IDLE;
            frm_done_q <= 1'b0;
            seq_err_q  <= 1'b0;
            frm_cnt_q  <= 7'd0;
            evt_cnt_q  <= 12'd0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            csum_q     <= csum_d;
            tx_data_q  <= tx_data_d;
            tx_k_q     <= tx_k_d;
            frm_done_q <= frm_done_d;
            seq_err_q  <= seq_err_d;
            frm_cnt_q  <= frm_cnt_d;
            evt_cnt_q  <= evt_cnt_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_k     = tx_k_q;
    assign frm_done = frm_done_q;
    assign seq_err  = seq_err_q;
    assign frm_cnt  = frm_cnt_q;
    assign evt_cnt  = evt_cnt_q;

endmodule

// File: tb/tb_chnlnk_frame_packer.sv
// -----------------------------------------------------------------------------
// tb_chnlnk_frame_packer
//
// Self-checking bench for chnlnk_frame_packer: directed frame scenarios, a
// table of short multi-cycle vectors, and randomized traffic compared against
// a frame-level reference model (checksum folded from a queue of words).
// -----------------------------------------------------------------------------
module tb_chnlnk_frame_packer;

    logic        clk;
    logic        rst_n;
    logic [15:0] din;
    logic        valid;
    logic [6:0]  seq;
    logic        clr_crc;
    logic        last_wrd;
    logic        clr_err;
    logic [15:0] tx_data;
    logic [1:0]  tx_k;
    logic        frm_done;
    logic        seq_err;
    logic [6:0]  frm_cnt;
    logic [11:0] evt_cnt;

    chnlnk_frame_packer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .valid    (valid),
        .seq      (seq),
        .clr_crc  (clr_crc),
        .last_wrd (last_wrd),
        .clr_err  (clr_err),
        .tx_data  (tx_data),
        .tx_k     (tx_k),
        .frm_done (frm_done),
        .seq_err  (seq_err),
        .frm_cnt  (frm_cnt),
        .evt_cnt  (evt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_in_frame;
    int          m_next;
    logic [15:0] m_hist[$];   // words folded into the checksum since last clear
    bit          m_err;
    int          m_frm;
    int          m_evt;
    logic [15:0] e_data;
    logic [1:0]  e_k;
    bit          e_done;

    task automatic model_reset();
        m_in_frame = 0;
        m_next     = 0;
        m_hist.delete();
        m_err      = 0;
        m_frm      = 0;
        m_evt      = 0;
        e_data     = 16'h50BC;
        e_k        = 2'b01;
        e_done     = 0;
    endtask

    function automatic logic [15:0] fold_csum();
        int unsigned c = 0;
        foreach (m_hist[j]) begin
            c = ((c << 1) | (c >> 15)) & 32'hFFFF;
            c = c ^ 32'(m_hist[j]);
        end
        return c[15:0];
    endfunction

    task automatic model_edge();
        bit          set_err = 0;
        logic [15:0] w;
        e_data = 16'h50BC;
        e_k    = 2'b01;
        e_done = 0;
        if (clr_crc) begin
            m_hist.delete();
            if (m_in_frame) set_err = 1;
            m_in_frame = 0;
            m_next     = 0;
        end else if (last_wrd) begin
            e_data = 16'hF7F7;
            e_k    = 2'b11;
            m_evt  = (m_evt + 1) % 4096;
            m_frm  = 0;
            if (m_in_frame) set_err = 1;
            m_in_frame = 0;
        end else if (valid) begin
            if (!m_in_frame) begin
                if (seq == 7'd0) begin
                    e_data = din; e_k = 2'b00;
                    m_hist.push_back(din);
                    m_in_frame = 1;
                    m_next     = 1;
                end else begin
                    set_err = 1;
                end
            end else if (int'(seq) != m_next) begin
                set_err    = 1;
                m_in_frame = 0;
            end else begin
                if (m_next <= 95) begin
                    e_data = din; e_k = 2'b00;
                    m_hist.push_back(din);
                end else if (m_next == 96) begin
                    w = 16'hD000 | (m_err ? 16'h0800 : 16'h0000) | 16'(m_frm);
                    e_data = w; e_k = 2'b00;
                    m_hist.push_back(w);
                end else if (m_next == 97) begin
                    e_data = fold_csum(); e_k = 2'b00;
                end else begin
                    e_data = 16'hFCF7; e_k = 2'b11; e_done = 1;
                    m_frm = (m_frm + 1) % 128;
                    m_in_frame = 0;
                end
                m_next++;
            end
        end
        m_err = set_err | (m_err & !clr_err);
    endtask

    // ---------------- drivers ----------------
    task automatic step(input logic v, input logic [6:0] s, input logic [15:0] d,
                        input logic cc, input logic lw, input logic ce);
        valid = v; seq = s; din = d; clr_crc = cc; last_wrd = lw; clr_err = ce;
        @(posedge clk);
        model_edge();
        #1;
        chk("model_tx_data", tx_data, e_data);
        chk("model_tx_k", tx_k, e_k);
        chk("model_frm_done", frm_done, e_done);
        chk("model_seq_err", seq_err, m_err);
        chk("model_frm_cnt", frm_cnt, m_frm);
        chk("model_evt_cnt", evt_cnt, m_evt);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_tx_data"}, tx_data, 16'h50BC);
        chk({tag, "_tx_k"}, tx_k, 2'b01);
        chk({tag, "_frm_done"}, frm_done, 1'b0);
        chk({tag, "_seq_err"}, seq_err, 1'b0);
        chk({tag, "_frm_cnt"}, frm_cnt, 7'd0);
        chk({tag, "_evt_cnt"}, evt_cnt, 12'd0);
    endtask

    task automatic hw_reset();
        valid = 0; seq = 0; din = 0; clr_crc = 0; last_wrd = 0; clr_err = 0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        model_reset();
    endtask

    // Sends SEQ 0..98 (first word = first, others zero), optionally skipping
    // one index or inserting an idle gap before one index.
    task automatic send_frame(input logic [15:0] first, input int skip, input int gap_at,
                              input int gap_len, output logic [15:0] o96,
                              output logic [15:0] o97, output logic [15:0] o98,
                              output logic [1:0] k98, output int dones);
        dones = 0; o96 = 0; o97 = 0; o98 = 0; k98 = 0;
        for (int i = 0; i < 99; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    step(1'b0, 7'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
                    chk("gap_word", tx_data, 16'h50BC);
                    chk("gap_k", tx_k, 2'b01);
                end
            end
            if (i == skip) continue;
            step(1'b1, 7'(i), (i == 0) ? first : 16'h0000, 1'b0, 1'b0, 1'b0);
            if (frm_done) dones++;
            if (skip >= 0 && i == skip + 1) begin
                chk("skip_seq_err", seq_err, 1'b1);
                chk("skip_idle_word", tx_data, 16'h50BC);
            end
            if (i == 96) o96 = tx_data;
            if (i == 97) o97 = tx_data;
            if (i == 98) begin o98 = tx_data; k98 = tx_k; end
        end
    endtask

    typedef struct {
        logic        v;
        logic [6:0]  s;
        logic [15:0] d;
        logic        cc;
        logic        lw;
        logic        ce;
        logic [15:0] xd;
        logic [1:0]  xk;
        logic        xerr;
        logic        xdone;
    } vec_t;

    vec_t        tbl[15];
    logic [15:0] o96, o97, o98;
    logic [1:0]  k98;
    int          dn;
    int          gseq;
    int          r;
    logic        rv, rcc, rlw, rce;
    logic [6:0]  rs;
    logic [15:0] rd;

    initial begin
        rst_n = 1'b0;
        valid = 0; seq = 0; din = 0; clr_crc = 0; last_wrd = 0; clr_err = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_reset_values("por");
        @(negedge clk) rst_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 7'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
            chk("idle_word", tx_data, 16'h50BC);
            chk("idle_k", tx_k, 2'b01);
        end

        // All-zero frame
        step(1'b0, 7'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
        send_frame(16'h0000, -1, -1, 0, o96, o97, o98, k98, dn);
        chk("a_status", o96, 16'hD000);
        chk("a_csum", o97, 16'hD000);
        chk("a_trailer", o98, 16'hFCF7);
        chk("a_trailer_k", k98, 2'b11);
        chk("a_done_count", dn, 1);
        chk("a_frm_cnt", frm_cnt, 7'd1);

        // Checksum propagation across two frames, then end of event
        hw_reset();
        step(1'b0, 7'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
        send_frame(16'h0001, -1, -1, 0, o96, o97, o98, k98, dn);
        chk("b1_status", o96, 16'hD000);
        chk("b1_csum", o97, 16'hD001);
        step(1'b0, 7'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
        send_frame(16'h0000, -1, -1, 0, o96, o97, o98, k98, dn);
        chk("b2_status", o96, 16'hD001);
        chk("b2_csum", o97, 16'hD001);
        step(1'b0, 7'd0, 16'h0000, 1'b0, 1'b1, 1'b0);
        chk("b_eoe_word", tx_data, 16'hF7F7);
        chk("b_eoe_k", tx_k, 2'b11);
        chk("b_evt_cnt", evt_cnt, 12'd1);
        chk("b_frm_cnt", frm_cnt, 7'd0);

        // Skipped index aborts the frame; next status word carries the error bit
        step(1'b0, 7'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
        send_frame(16'h0000, 40, -1, 0, o96, o97, o98, k98, dn);
        chk("c_no_done", dn, 0);
        step(1'b0, 7'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
        send_frame(16'h0000, -1, -1, 0, o96, o97, o98, k98, dn);
        chk("c_status", o96, 16'hD800);
        chk("c_csum", o97, 16'hD800);
        chk("c_done_count", dn, 1);
        step(1'b0, 7'd0, 16'h0000, 1'b0, 1'b0, 1'b1);
        chk("c_clr_err", seq_err, 1'b0);

        // Three-cycle gap at index 50
        step(1'b0, 7'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
        send_frame(16'h0000, -1, 50, 3, o96, o97, o98, k98, dn);
        chk("d_status", o96, 16'hD001);
        chk("d_csum", o97, 16'hD001);
        chk("d_trailer", o98, 16'hFCF7);
        chk("d_done_count", dn, 1);

        // Asynchronous reset mid-frame at index 60
        step(1'b0, 7'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 60; i++) step(1'b1, 7'(i), 16'h1234, 1'b0, 1'b0, 1'b0);
        valid = 1'b1; seq = 7'd60; din = 16'h5555;
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_rst");
        repeat (2) @(posedge clk);
        seq = 7'd61;
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        step(1'b0, 7'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
        send_frame(16'h0000, -1, -1, 0, o96, o97, o98, k98, dn);
        chk("e_status", o96, 16'hD000);
        chk("e_csum", o97, 16'hD000);
        chk("e_done_count", dn, 1);

        // Short multi-cycle vectors: {v, seq, din, clr_crc, last_wrd, clr_err, data, k, err, done}
        tbl[0]  = '{1'b0, 7'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h50BC, 2'b01, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 7'd5, 16'h9999, 1'b0, 1'b0, 1'b0, 16'h50BC, 2'b01, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 7'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h50BC, 2'b01, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 7'd0, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h1234, 2'b00, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 7'd1, 16'hABCD, 1'b0, 1'b0, 1'b0, 16'hABCD, 2'b00, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 7'd2, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h50BC, 2'b01, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 7'd2, 16'h0055, 1'b0, 1'b0, 1'b0, 16'h0055, 2'b00, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 7'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'hF7F7, 2'b11, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 7'd0, 16'h4444, 1'b1, 1'b0, 1'b0, 16'h50BC, 2'b01, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 7'd0, 16'h7777, 1'b0, 1'b0, 1'b1, 16'h7777, 2'b00, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 7'd1, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0001, 2'b00, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 7'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h50BC, 2'b01, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 7'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h50BC, 2'b01, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 7'd9, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h50BC, 2'b01, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 7'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h50BC, 2'b01, 1'b0, 1'b0};
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].cc, tbl[i].lw, tbl[i].ce);
            chk($sformatf("vec%0d_data", i), tx_data, tbl[i].xd);
            chk($sformatf("vec%0d_k", i), tx_k, tbl[i].xk);
            chk($sformatf("vec%0d_err", i), seq_err, tbl[i].xerr);
            chk($sformatf("vec%0d_done", i), frm_done, tbl[i].xdone);
        end

        // Randomized traffic against the reference model
        gseq = 0;
        for (int c = 0; c < 5000; c++) begin
            r   = $urandom_range(0, 999);
            rcc = (r < 5);
            rlw = (r >= 5 && r < 7);
            rce = ($urandom_range(0, 79) == 0);
            rv  = ($urandom_range(0, 9) != 0);
            rd  = 16'($urandom);
            rs  = 7'(gseq);
            if (rv && $urandom_range(0, 299) == 0) rs = 7'($urandom_range(0, 98));
            if (rv) gseq = (gseq + 1) % 99;
            if (rcc) gseq = 0;
            step(rv, rs, rd, rcc, rlw, rce);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/chnlnk_frame_packer.md
# chnlnk_frame_packer

Downstream stage of the channel-link frame sequencer. It consumes the sequencer's per-sample word stream (VALID, SEQ, CLR_CRC, LAST_WRD plus the FIFO data word) and produces a registered 16-bit 8b/10b-ready word stream for the optical transmitter. Within each frame it inserts the status, checksum and trailer words, and fills the gaps between frames with idle commas. It also checks sequence continuity and counts frames and events.

## Interface
- IDLE_WORD, 16'h50BC: inter-frame filler, TX_K=2'b01 (K28.5 in the low byte).
- TRL_WORD, 16'hFCF7: end-of-frame trailer, TX_K=2'b11.
- EOE_WORD, 16'hF7F7: end-of-event marker, TX_K=2'b11.
- CLK  in  1  system clock; all logic on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- DIN  in  16  ADC data word; qualified by VALID.
- VALID  in  1  a word is presented this cycle.
- SEQ  in  7  word index within the frame, 0..98.
- CLR_CRC  in  1  one-cycle pulse at the start of each frame (waiting for data).
- LAST_WRD  in  1  one-cycle pulse after the last frame of an event.
- CLR_ERR  in  1  synchronous clear of SEQ_ERR.
- TX_DATA  out  16  output word.
- TX_K  out  2  K-character flags, one per byte (bit0 = low byte).
- FRM_DONE  out  1  one-cycle pulse when the trailer is output.
- SEQ_ERR  out  1  sticky sequence-error flag.
- FRM_CNT  out  7  frames sent in the current event.
- EVT_CNT  out  12  events completed; wraps at 4095→0.

## Operation
- States:
  - IDLE: outputs IDLE_WORD, K=01.
  - FRAME: passes frame words through.
- Expected-index register `exp` (7b).
- Checksum register `csum` (16b), updated on every emitted word with index 0..96: csum ← {csum[14:0],csum[15]} ^ word.
- CLR_CRC (any state): csum←0, exp←0, go to IDLE.
  - If it arrives while in FRAME with exp≠0, the frame is aborted: set SEQ_ERR and emit IDLE_WORD.
  - CLR_CRC has priority over a coincident VALID; that word is dropped.
- IDLE, VALID with SEQ=0: emit DIN, K=00, go to FRAME, exp←1.
- IDLE, VALID with SEQ≠0: drop the word, set SEQ_ERR, stay in IDLE.
- FRAME, VALID with SEQ≠exp: set SEQ_ERR, emit IDLE_WORD, go to IDLE. The rest of the frame is discarded until the next SEQ=0.
- FRAME, VALID with SEQ=exp, output by index (exp←exp+1 each time):
  - 1..95: emit DIN, K=00.
  - 96: emit the status word {4'hD, SEQ_ERR, 4'b0000, FRM_CNT}, K=00; DIN is ignored.
  - 97: emit the current csum value (status word already included), K=00.
  - 98: emit TRL_WORD, K=11; pulse FRM_DONE; FRM_CNT←FRM_CNT+1 (wraps at 127); go to IDLE.
- FRAME with VALID low: emit IDLE_WORD, K=01, and stay in FRAME (gap insertion).
- LAST_WRD: emit EOE_WORD, K=11 that cycle; EVT_CNT+1; FRM_CNT←0.
  - If LAST_WRD arrives while in FRAME: set SEQ_ERR and go to IDLE.
- CLR_ERR clears SEQ_ERR. A same-cycle error set wins over the clear.

## Timing
- TX_DATA, TX_K and FRM_DONE are registered, with one cycle of latency from the input cycle.
- Input word n at edge t appears at edge t+1. Back-to-back VALID gives back-to-back output.
- The checksum word for index 97 uses csum updated through index 96 at the preceding edge; no extra bubble is added.
- Reset (RST_N low, asynchronous) forces:
  - TX_DATA=16'h50BC, TX_K=2'b01, FRM_DONE=0;
  - SEQ_ERR=0, FRM_CNT=0, EVT_CNT=0;
  - csum=0, exp=0, state IDLE.
- Reset released mid-frame: resume in IDLE and wait for SEQ=0. Inputs presented during reset are ignored.

## Test plan
- After reset, idle for 10 cycles → TX_DATA=50BC, TX_K=01 every cycle; all flags 0.
- CLR_CRC, then 99 consecutive VALID words, SEQ 0..98, DIN=0 → at output index 96 0xD000, index 97 0xD000, index 98 FCF7/K=11; FRM_DONE pulses once; FRM_CNT=1.
- Same frame but DIN=0x0001 at SEQ 0 only, then a second frame of zeros → frame 1 checksum 0xD001; frame 2 status 0xD001 and checksum 0xD001; then LAST_WRD → F7F7/K=11, EVT_CNT=1, FRM_CNT=0.
- Skip SEQ 40 (jump from 39 to 41) → SEQ_ERR=1, IDLE_WORD output from that cycle, no trailer or FRM_DONE. The next clean frame's status word is 0xD800 + FRM_CNT. CLR_ERR → SEQ_ERR=0.
- Drop VALID for 3 cycles at SEQ 50 → three 50BC/K=01 words inserted; frame otherwise intact with correct checksum.
- Assert RST_N low at SEQ 60 for 2 cycles, then start a fresh frame → all outputs return to reset values asynchronously; the next frame packs with status word 0xD000.
